// File: rtl/mips_pkg.sv
// Shared register-file types and constants for the write-back path.
package mips_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

    // Source feeding the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_sel_e;

    // One buffered load result.
    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Parameterized-depth synchronous FIFO with wrap-around pointers and an occupancy count.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port arbiter: ALU results take priority, load results queue
// in a small FIFO, and a per-register scoreboard tracks outstanding writes.
module rf_writeback
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int SP_REG     = 29
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_reg,
    input  logic [31:0]                   alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [4:0]                    mem_reg,
    input  logic [31:0]                   mem_data,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_reg,
    input  logic [4:0]                    query_reg1,
    input  logic [4:0]                    query_reg2,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          rf_write,
    output logic [4:0]                    rf_write_reg,
    output logic [31:0]                   rf_write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SP_REG < 1 || SP_REG > 31) begin : g_bad_param
        $error("rf_writeback: FIFO_DEPTH must be a power of two >= 2 and SP_REG in 1..31");
    end

    wb_sel_e   sel;
    reg_idx_t  sel_reg;
    word_t     sel_data;
    logic      sel_valid;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;
    wb_entry_t fifo_din;
    wb_entry_t fifo_head;
    logic [31:1] busy_q;
    logic [31:1] busy_d;

    // Strict priority: a non-zero ALU result, else the FIFO head, else nothing.
    always_comb begin
        sel      = WB_NONE;
        sel_reg  = alu_reg;
        sel_data = alu_data;
        fifo_pop = 1'b0;
        if (alu_valid && alu_reg != REG_ZERO) begin
            sel = WB_ALU;
        end else if (!fifo_empty) begin
            sel      = WB_MEM;
            sel_reg  = fifo_head.rd;
            sel_data = fifo_head.data;
            fifo_pop = 1'b1;
        end
    end

    assign sel_valid = (sel != WB_NONE);

    // Load handshake: a transfer occurs on mem_valid && mem_ready; the producer
    // holds mem_reg/mem_data stable while mem_valid is high and mem_ready is low.
    // A full FIFO still accepts when its head drains in the same cycle.
    assign mem_ready = !fifo_full || fifo_pop;
    assign fifo_push = mem_valid && mem_ready && (mem_reg != REG_ZERO);
    assign fifo_din  = '{rd: mem_reg, data: mem_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write      <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write <= sel_valid;
            if (sel_valid) begin
                rf_write_reg  <= sel_reg;
                rf_write_data <= sel_data;
            end
        end
    end

    // A new issue to a register outranks the clear from its previous producer.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r <= 31; r++) begin
            if (sel_valid && sel_reg == reg_idx_t'(r)) busy_d[r] = 1'b0;
            if (issue_valid && issue_reg == reg_idx_t'(r)) busy_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // The write selected now lands next cycle, which is when decode reads the file.
    assign busy1 = (query_reg1 != REG_ZERO) && busy_q[query_reg1] &&
                   !(sel_valid && sel_reg == query_reg1);
    assign busy2 = (query_reg2 != REG_ZERO) && busy_q[query_reg2] &&
                   !(sel_valid && sel_reg == query_reg2);

endmodule
